poolb_row_pair_feeder: RTL



---
 rtl/poolb_row_pair_feeder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/poolb_row_pair_feeder.sv
// Row-pair feeder for the 3-lane 2x2 pooling datapath: buffers even rows, emits (upper, lower) pairs on odd rows.
// Optional build macro POOLB_FEEDER_STATS_EN adds dropped_beats / frame_err diagnostics.
module poolb_row_pair_feeder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned IFM_SIZE    = 10,
  parameter int unsigned IFM_DEPTH   = 16,
  parameter int unsigned KERNAL_SIZE = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in_1,
  input  logic [DATA_WIDTH-1:0] data_in_2,
  input  logic [DATA_WIDTH-1:0] data_in_3,
  output logic [DATA_WIDTH-1:0] data_out_A_1,
  output logic [DATA_WIDTH-1:0] data_out_A_2,
  output logic [DATA_WIDTH-1:0] data_out_A_3,
  output logic [DATA_WIDTH-1:0] data_out_B_1,
  output logic [DATA_WIDTH-1:0] data_out_B_2,
  output logic [DATA_WIDTH-1:0] data_out_B_3,
  output logic                  fifo_enable,
  output logic                  pool_enable,
`ifdef POOLB_FEEDER_STATS_EN
  output logic [15:0]           dropped_beats,
  output logic                  frame_err,
`endif
  output logic                  done
);

  localparam int unsigned MAPS = (IFM_DEPTH + 2) / 3;
  localparam int unsigned SPAN = 2 * (IFM_SIZE / 2);
  localparam int unsigned CW   = $clog2(IFM_SIZE);
  localparam int unsigned MW   = (MAPS > 1) ? $clog2(MAPS) : 1;
  localparam int unsigned LW   = $clog2(SPAN);
  localparam int unsigned BW   = 3 * DATA_WIDTH;

  if (KERNAL_SIZE != 2) begin : g_kernel_chk
    $error("poolb_row_pair_feeder: only KERNAL_SIZE=2 is supported");
  end
  if (IFM_SIZE < 2) begin : g_size_chk
    $error("poolb_row_pair_feeder: IFM_SIZE must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, row_q;
  logic [MW-1:0]   map_q;
  logic [BW-1:0]   line_buf [SPAN];

  logic accept_c, col_last_c, row_last_c, map_last_c, col_in_c, row_in_c;
  logic buf_wr_c, strobe_c;

  assign accept_c   = in_valid && in_ready;
  assign col_last_c = (col_q == CW'(IFM_SIZE - 1));
  assign row_last_c = (row_q == CW'(IFM_SIZE - 1));
  assign map_last_c = (map_q == MW'(MAPS - 1));
  assign col_in_c   = (32'(col_q) < SPAN);
  assign row_in_c   = (32'(row_q) < SPAN);
  // Even rows fill the line buffer, odd rows pair against it; trailing odd col/row are dropped
  assign buf_wr_c   = accept_c && !row_q[0] && row_in_c && col_in_c;
  assign strobe_c   = accept_c && row_q[0] && col_in_c;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept_c && col_last_c && row_last_c && map_last_c) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      map_q        <= '0;
      in_ready     <= 1'b0;
      done         <= 1'b0;
      fifo_enable  <= 1'b0;
      pool_enable  <= 1'b0;
      data_out_A_1 <= '0;
      data_out_A_2 <= '0;
      data_out_A_3 <= '0;
      data_out_B_1 <= '0;
      data_out_B_2 <= '0;
      data_out_B_3 <= '0;
    end else begin
      state_q     <= state_d;
      in_ready    <= (state_d == RUN);
      done        <= (state_q == DONE);
      fifo_enable <= strobe_c;
      pool_enable <= strobe_c && col_q[0];
      if (state_q == IDLE && start) begin
        col_q <= '0;
        row_q <= '0;
        map_q <= '0;
      end else if (accept_c) begin
        col_q <= col_last_c ? '0 : col_q + CW'(1);
        if (col_last_c) begin
          row_q <= row_last_c ? '0 : row_q + CW'(1);
          if (row_last_c) map_q <= map_last_c ? '0 : map_q + MW'(1);
        end
      end
      if (strobe_c) begin
        data_out_A_1 <= line_buf[col_q[LW-1:0]][DATA_WIDTH-1:0];
        data_out_A_2 <= line_buf[col_q[LW-1:0]][2*DATA_WIDTH-1:DATA_WIDTH];
        data_out_A_3 <= line_buf[col_q[LW-1:0]][3*DATA_WIDTH-1:2*DATA_WIDTH];
        data_out_B_1 <= data_in_1;
        data_out_B_2 <= data_in_2;
        data_out_B_3 <= data_in_3;
      end
    end
  end

  // Line buffer needs no reset: each cell is written on an even row before its odd-row read
  always_ff @(posedge clk) begin
    if (buf_wr_c) line_buf[col_q[LW-1:0]] <= {data_in_3, data_in_2, data_in_1};
  end

`ifdef POOLB_FEEDER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dropped_beats <= '0;
      frame_err     <= 1'b0;
    end else begin
      if (start) dropped_beats <= '0;
      else if (in_valid && !in_ready && dropped_beats != 16'hFFFF) dropped_beats <= dropped_beats + 16'd1;
      if (start && state_q == RUN) frame_err <= 1'b1;
    end
  end
`endif

endmodule
